// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- MIPS instruction-fetch stage with the IF/ID pipeline register.
//
// Owns the program counter, selects the next PC (sequential, branch, jump,
// jump-register), runs the request handshake to instruction memory and
// registers the fetched instruction plus its PC+4 for the decode stage.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   stall            hold PC and IF/ID (hazard unit)
//   flush            write a bubble into IF/ID this cycle
//   branch_taken     EX-stage branch resolved taken, target on branch_target
//   jump_reg         ID-stage jr, target on jump_reg_target
//   jump             ID-stage j/jal, index on jump_index
//   imem_req         fetch request to instruction memory
//   imem_addr        fetch address (the PC)
//   imem_rdata       instruction word, valid while imem_ready=1
//   imem_ready       memory completes the request this cycle
//   if_id_instr      registered instruction
//   if_id_pc_plus4   registered PC+4 of that instruction
//   if_id_opcode     if_id_instr[31:26], feeds the control unit OP input
//   if_id_valid      IF/ID holds a real instruction
//   fetch_busy       request outstanding (REQ with imem_ready=0)
//
// Memory handshake: while imem_req=1 the address is held stable; the
// transfer completes on a rising edge where imem_ready=1, and imem_rdata is
// sampled on that same edge. imem_req drops in BOOT and HELD.
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic [5:0]  if_id_opcode,
  output logic        if_id_valid,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_HELD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;

  logic        redirect;
  logic [31:0] redirect_tgt;
  logic [31:0] seq_pc4;

  // PC+4 wraps naturally modulo 2^32.
  assign seq_pc4 = pc_q + 32'd4;

  // Redirect source priority: branch (older, from EX) beats jr beats j.
  // The jump region comes from the PC+4 of the jump sitting in IF/ID.
  assign redirect = branch_taken | jump_reg | jump;

  always_comb begin
    if (branch_taken) begin
      redirect_tgt = branch_target;
    end else if (jump_reg) begin
      redirect_tgt = jump_reg_target;
    end else begin
      redirect_tgt = {if_id_pc4_q[31:28], jump_index, 2'b00};
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    pend_d        = pend_q;
    pend_tgt_d    = pend_tgt_q;
    hold_instr_d  = hold_instr_q;
    hold_pc4_d    = hold_pc4_q;
    imem_req      = 1'b0;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_REQ;
        if (redirect) begin
          pc_d          = redirect_tgt;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end else if (flush) begin
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end
      end

      ST_REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          // New redirect always bubbles IF/ID and overrides stall. With the
          // response arriving now it is dropped and the target applied; if
          // the request is still outstanding the target waits in pend.
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
          if (imem_ready) begin
            pc_d   = redirect_tgt;
            pend_d = 1'b0;
          end else begin
            pend_d     = 1'b1;
            pend_tgt_d = redirect_tgt;
          end
        end else if (pend_q) begin
          // The in-flight word belongs to the wrong path: discard it.
          if (flush || imem_ready) begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
          end
          if (imem_ready) begin
            pc_d   = pend_tgt_q;
            pend_d = 1'b0;
          end
        end else if (imem_ready) begin
          if (stall) begin
            // Park the word so the memory handshake can complete while
            // decode is frozen.
            hold_instr_d = imem_rdata;
            hold_pc4_d   = seq_pc4;
            state_d      = ST_HELD;
            if (flush) begin
              if_id_instr_d = NOP_INSTR;
              if_id_valid_d = 1'b0;
            end
          end else begin
            pc_d = seq_pc4;
            if (flush) begin
              if_id_instr_d = NOP_INSTR;
              if_id_valid_d = 1'b0;
            end else begin
              if_id_instr_d = imem_rdata;
              if_id_pc4_d   = seq_pc4;
              if_id_valid_d = 1'b1;
            end
          end
        end else if (flush) begin
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end
      end

      ST_HELD: begin
        if (redirect) begin
          pc_d          = redirect_tgt;
          hold_instr_d  = 32'd0;
          hold_pc4_d    = 32'd0;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
          state_d       = ST_REQ;
        end else if (!stall) begin
          pc_d    = hold_pc4_q;
          state_d = ST_REQ;
          if (flush) begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
          end else begin
            if_id_instr_d = hold_instr_q;
            if_id_pc4_d   = hold_pc4_q;
            if_id_valid_d = 1'b1;
          end
        end else if (flush) begin
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= PC_RESET;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc4_q   <= 32'd0;
      if_id_valid_q <= 1'b0;
      pend_q        <= 1'b0;
      pend_tgt_q    <= 32'd0;
      hold_instr_q  <= 32'd0;
      hold_pc4_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      pend_q        <= pend_d;
      pend_tgt_q    <= pend_tgt_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc4_q    <= hold_pc4_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_pc_plus4 = if_id_pc4_q;
  assign if_id_opcode   = if_id_instr_q[31:26];
  assign if_id_valid    = if_id_valid_q;
  assign fetch_busy     = (state_q == ST_REQ) && !imem_ready;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- directed bench for if_stage. A tiny instruction memory
// answers whatever address the stage presents; imem_ready is driven by the
// directed steps below.
// ---------------------------------------------------------------------------
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_reg;
  logic [31:0] jump_reg_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic [5:0]  if_id_opcode;
  logic        if_id_valid;
  logic        fetch_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .flush           (flush),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .jump_reg        (jump_reg),
    .jump_reg_target (jump_reg_target),
    .jump            (jump),
    .jump_index      (jump_index),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .if_id_instr     (if_id_instr),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_opcode    (if_id_opcode),
    .if_id_valid     (if_id_valid),
    .fetch_busy      (fetch_busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: one fixed word at the reset vector, otherwise an
  // addiu whose low half echoes the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    return {16'h2400, a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    reset           = 1'b0;
    stall           = 1'b0;
    flush           = 1'b0;
    branch_taken    = 1'b0;
    branch_target   = 32'd0;
    jump_reg        = 1'b0;
    jump_reg_target = 32'd0;
    jump            = 1'b0;
    jump_index      = 26'd0;
    imem_ready      = 1'b1;

    // Reset values
    repeat (2) tick();
    check("rst_instr", if_id_instr, 32'h0000_0000);
    check("rst_pc4",   if_id_pc_plus4, 32'h0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_addr",  imem_addr, 32'h0040_0000);

    // BOOT for one cycle, then back-to-back zero-wait fetch
    reset = 1'b1;
    tick();
    check("boot_req",   {31'd0, imem_req}, 32'd1);
    check("boot_valid", {31'd0, if_id_valid}, 32'd0);
    tick();
    check("f0_instr",  if_id_instr, 32'h2008_0005);
    check("f0_opcode", {26'd0, if_id_opcode}, 32'h08);
    check("f0_pc4",    if_id_pc_plus4, 32'h0040_0004);
    check("f0_valid",  {31'd0, if_id_valid}, 32'd1);
    check("f0_addr",   imem_addr, 32'h0040_0004);
    tick();
    check("f1_instr", if_id_instr, 32'h2400_0004);
    check("f1_addr",  imem_addr, 32'h0040_0008);

    // Wait states at 0x00400008
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ws_busy",  {31'd0, fetch_busy}, 32'd1);
      check("ws_addr",  imem_addr, 32'h0040_0008);
      check("ws_instr", if_id_instr, 32'h2400_0004);
      tick();
    end
    imem_ready = 1'b1;
    #1;
    check("ws_busy_off", {31'd0, fetch_busy}, 32'd0);
    tick();
    check("ws_land_instr", if_id_instr, 32'h2400_0008);
    check("ws_land_pc4",   if_id_pc_plus4, 32'h0040_000C);
    check("ws_next_addr",  imem_addr, 32'h0040_000C);

    // Stall two cycles while memory answers
    stall = 1'b1;
    tick();
    check("st1_req",   {31'd0, imem_req}, 32'd0);
    check("st1_instr", if_id_instr, 32'h2400_0008);
    check("st1_addr",  imem_addr, 32'h0040_000C);
    tick();
    check("st2_req",   {31'd0, imem_req}, 32'd0);
    check("st2_instr", if_id_instr, 32'h2400_0008);
    stall = 1'b0;
    tick();
    check("st_rel_instr", if_id_instr, 32'h2400_000C);
    check("st_rel_pc4",   if_id_pc_plus4, 32'h0040_0010);
    check("st_rel_valid", {31'd0, if_id_valid}, 32'd1);
    check("st_rel_addr",  imem_addr, 32'h0040_0010);
    check("st_rel_req",   {31'd0, imem_req}, 32'd1);

    // Jump: {4'h0, 26'h0100000, 2'b00} = 0x00400000
    jump       = 1'b1;
    jump_index = 26'h010_0000;
    tick();
    jump = 1'b0;
    check("j_addr",   imem_addr, 32'h0040_0000);
    check("j_valid",  {31'd0, if_id_valid}, 32'd0);
    check("j_opcode", {26'd0, if_id_opcode}, 32'd0);
    check("j_pc4",    if_id_pc_plus4, 32'h0040_0010);

    // Branch while a request is outstanding: returned word discarded
    imem_ready    = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h0040_0040;
    tick();
    branch_taken = 1'b0;
    check("br_pend_addr", imem_addr, 32'h0040_0000);
    check("br_pend_busy", {31'd0, fetch_busy}, 32'd1);
    tick();
    imem_ready = 1'b1;
    tick();
    check("br_addr",  imem_addr, 32'h0040_0040);
    check("br_valid", {31'd0, if_id_valid}, 32'd0);
    check("br_instr", if_id_instr, 32'h0000_0000);
    tick();
    check("br_land_instr", if_id_instr, 32'h2400_0040);
    check("br_land_pc4",   if_id_pc_plus4, 32'h0040_0044);

    // Branch + jr + stall together: branch wins, stall ignored
    branch_taken    = 1'b1;
    branch_target   = 32'hFFFF_FFFC;
    jump_reg        = 1'b1;
    jump_reg_target = 32'h1234_5678;
    stall           = 1'b1;
    tick();
    branch_taken = 1'b0;
    jump_reg     = 1'b0;
    stall        = 1'b0;
    check("pri_addr",  imem_addr, 32'hFFFF_FFFC);
    check("pri_valid", {31'd0, if_id_valid}, 32'd0);
    check("pri_req",   {31'd0, imem_req}, 32'd1);
    tick();
    check("wrap_instr", if_id_instr, 32'h2400_FFFC);
    check("wrap_pc4",   if_id_pc_plus4, 32'h0000_0000);
    check("wrap_addr",  imem_addr, 32'h0000_0000);

    // Flush drops the fetched word, PC still advances
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid", {31'd0, if_id_valid}, 32'd0);
    check("fl_instr", if_id_instr, 32'h0000_0000);
    check("fl_pc4",   if_id_pc_plus4, 32'h0000_0000);
    check("fl_addr",  imem_addr, 32'h0000_0004);

    // jr beats j
    jump_reg        = 1'b1;
    jump_reg_target = 32'h0040_0100;
    jump            = 1'b1;
    jump_index      = 26'h3FF_FFFF;
    tick();
    jump_reg = 1'b0;
    jump     = 1'b0;
    check("jr_addr", imem_addr, 32'h0040_0100);

    // Reset in the middle of an outstanding request
    imem_ready = 1'b0;
    tick();
    check("mid_busy", {31'd0, fetch_busy}, 32'd1);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_addr",  imem_addr, 32'h0040_0000);
    check("mid_rst_req",   {31'd0, imem_req}, 32'd0);
    check("mid_rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("mid_rst_busy",  {31'd0, fetch_busy}, 32'd0);
    imem_ready = 1'b1;
    #2 reset = 1'b1;
    tick();
    tick();
    check("post_rst_instr", if_id_instr, 32'h2008_0005);
    check("post_rst_valid", {31'd0, if_id_valid}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
